// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type, and datapath sizing constants.
package md_pkg;

  localparam int MD_WIDTH = 32;  // operand / HI / LO width
  localparam int MD_ITER  = 32;  // iterations per operation, equal to width

  // MDOp encodings; 3'b110 and 3'b111 are no-ops
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Sign handling shared by multiply and divide.
// Entry side: magnitudes of both operands plus their sign bits (signs are
// forced to 0 for unsigned operations).
// Exit side: conditional two's-complement of the full 2W-bit product, and
// independent conditional negation of the upper half (remainder) and lower
// half (quotient) of the same word.
//   a_i, b_i, signed_i      : raw operands and signed-operation flag
//   abs_a_o, abs_b_o        : operand magnitudes
//   neg_a_o, neg_b_o        : operand is negative (signed ops only)
//   wide_i, neg_wide_i      : raw 2W-bit result and its negate request
//   wide_o                  : sign-corrected product
//   neg_hi_i, hi_o          : remainder (upper half) negate request / result
//   neg_lo_i, lo_o          : quotient (lower half) negate request / result
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           signed_i,
  output logic [W-1:0]   abs_a_o,
  output logic [W-1:0]   abs_b_o,
  output logic           neg_a_o,
  output logic           neg_b_o,
  input  logic [2*W-1:0] wide_i,
  input  logic           neg_wide_i,
  output logic [2*W-1:0] wide_o,
  input  logic           neg_hi_i,
  output logic [W-1:0]   hi_o,
  input  logic           neg_lo_i,
  output logic [W-1:0]   lo_o
);

  // Operand magnitudes; the most negative value maps onto itself, which is
  // its correct unsigned magnitude.
  always_comb begin
    neg_a_o = signed_i & a_i[W-1];
    neg_b_o = signed_i & b_i[W-1];
    abs_a_o = neg_a_o ? -a_i : a_i;
    abs_b_o = neg_b_o ? -b_i : b_i;
  end

  // Result sign correction.
  always_comb begin
    wide_o = neg_wide_i ? -wide_i : wide_i;
    hi_o   = neg_hi_i ? -wide_i[2*W-1:W] : wide_i[2*W-1:W];
    lo_o   = neg_lo_i ? -wide_i[W-1:0] : wide_i[W-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run one radix-2 step per cycle for ITER cycles on
// operand magnitudes; the sign is fixed up on the completing edge. MTHI/MTLO
// write HI/LO directly from SrcA without going busy.
//   clk, rst   : clock, synchronous active-high reset
//   Start      : request, only honoured while Busy=0
//   MDOp       : operation select (see md_pkg)
//   SrcA, SrcB : rs / rt operands
//   Busy       : operation in flight (stall request)
//   HI, LO     : architectural HI / LO registers
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int               CNT_W     = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             is_mul_q;
  logic             neg_res_q;   // product / quotient needs negation
  logic             neg_rem_q;   // remainder follows the dividend sign
  logic             div_zero_q;
  logic [WIDTH-1:0] operand_q;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] work_hi_q;   // product high half / partial remainder
  logic [WIDTH-1:0] work_lo_q;   // multiplier bits / dividend-quotient bits
  logic [WIDTH-1:0] raw_a_q;     // unmodified SrcA for divide-by-zero HI
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic               op_signed_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic               neg_a_s;
  logic               neg_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_sh_s;
  logic [WIDTH-1:0]   step_hi_d;
  logic [WIDTH-1:0]   step_lo_d;
  logic [2*WIDTH-1:0] fix_wide_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  assign op_signed_s = (MDOp == MD_MULT) || (MDOp == MD_DIV);

  md_sign_fix #(.W(WIDTH)) u_sign_fix (
    .a_i        (SrcA),
    .b_i        (SrcB),
    .signed_i   (op_signed_s),
    .abs_a_o    (abs_a_s),
    .abs_b_o    (abs_b_s),
    .neg_a_o    (neg_a_s),
    .neg_b_o    (neg_b_s),
    .wide_i     ({step_hi_d, step_lo_d}),
    .neg_wide_i (neg_res_q),
    .wide_o     (fix_wide_s),
    .neg_hi_i   (neg_rem_q),
    .hi_o       (fix_hi_s),
    .neg_lo_i   (neg_res_q),
    .lo_o       (fix_lo_s)
  );

  // One iteration step. Multiply: add multiplicand when the current
  // multiplier bit is set, then shift the 2W-bit accumulator right.
  // Divide: shift the next dividend bit into the remainder and subtract the
  // divisor when it fits (the W-bit subtraction is exact in that case).
  // A zero divisor always "fits", giving an all-ones quotient.
  always_comb begin
    mul_sum_s = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});
    div_sh_s  = {work_hi_q, work_lo_q[WIDTH-1]};
    if (is_mul_q) begin
      step_hi_d = mul_sum_s[WIDTH:1];
      step_lo_d = {mul_sum_s[0], work_lo_q[WIDTH-1:1]};
    end else if (div_sh_s >= {1'b0, operand_q}) begin
      step_hi_d = div_sh_s[WIDTH-1:0] - operand_q;
      step_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_hi_d = div_sh_s[WIDTH-1:0];
      step_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, operand latch, iteration registers and HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      is_mul_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      operand_q  <= '0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      raw_a_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            case (MDOp)
              MD_MTHI: hi_q <= SrcA;
              MD_MTLO: lo_q <= SrcA;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                // MDOp[1] distinguishes divide from multiply
                is_mul_q   <= ~MDOp[1];
                operand_q  <= MDOp[1] ? abs_b_s : abs_a_s;
                work_lo_q  <= MDOp[1] ? abs_a_s : abs_b_s;
                work_hi_q  <= '0;
                neg_res_q  <= neg_a_s ^ neg_b_s;
                neg_rem_q  <= neg_a_s;
                div_zero_q <= (SrcB == {WIDTH{1'b0}});
                raw_a_q    <= SrcA;
                cnt_q      <= '0;
                busy_q     <= 1'b1;
                state_q    <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          work_hi_q <= step_hi_d;
          work_lo_q <= step_lo_d;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (is_mul_q) begin
              {hi_q, lo_q} <= fix_wide_s;
            end else if (div_zero_q) begin
              hi_q <= raw_a_q;
              lo_q <= '1;
            end else begin
              hi_q <= fix_hi_s;
              lo_q <= fix_lo_s;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_mul_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] cur_hi = 32'h0;   // model view of HI
  logic [31:0] cur_lo = 32'h0;   // model view of LO

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .MDOp  (MDOp),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  // Reference result {HI,LO} from ordinary integer arithmetic.
  function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: p = sa * sb;
      3'b001: p = {32'h0, a} * {32'h0, b};
      3'b010: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'b011: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
      default: p = {cur_hi, cur_lo};
    endcase
    return p;
  endfunction

  // Issue one iterative op, check Busy length, HI/LO stability and result.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject, input string name);
    logic [63:0] expv;
    int cycles;
    expv = md_model(op, a, b);
    @(negedge clk);
    Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; MDOp = 3'($urandom_range(0, 7));
    total++;
    if (Busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_after_accept got=%b want=1", name, Busy);
    end
    cycles = 0;
    while (Busy === 1'b1 && cycles < 100) begin
      total++;
      if (HI !== cur_hi || LO !== cur_lo) begin
        bad++; $display("FAIL %s hilo_stable cyc=%0d got=%h_%h want=%h_%h", name, cycles, HI, LO, cur_hi, cur_lo);
      end
      if (inject) begin
        @(negedge clk);
        Start = 1'b1;
        case ($urandom_range(0, 3))
          0: MDOp = MD_MTLO;
          1: MDOp = MD_MTHI;
          2: MDOp = MD_MULT;
          default: MDOp = MD_DIVU;
        endcase
        SrcA = $urandom; SrcB = $urandom;
      end
      @(posedge clk); #1;
      cycles++;
    end
    Start = 1'b0;
    total++;
    if (cycles != 32) begin
      bad++; $display("FAIL %s busy_cycles got=%0d want=32", name, cycles);
    end
    total++;
    if (HI !== expv[63:32]) begin
      bad++; $display("FAIL %s hi op=%0d a=%h b=%h got=%h want=%h", name, op, a, b, HI, expv[63:32]);
    end
    total++;
    if (LO !== expv[31:0]) begin
      bad++; $display("FAIL %s lo op=%0d a=%h b=%h got=%h want=%h", name, op, a, b, LO, expv[31:0]);
    end
    cur_hi = expv[63:32];
    cur_lo = expv[31:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; MDOp = 3'b000; SrcA = 32'h0; SrcB = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    Start = 1'b1; MDOp = MD_MTHI; SrcA = 32'h1111_2222;
    @(posedge clk); #1; Start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      bad++; $display("FAIL reset_state got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO);
    end
    @(negedge clk); rst = 1'b0;
    cur_hi = 32'h0; cur_lo = 32'h0;
  endtask

  task automatic test_directed();
    do_op(MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 1'b0, "mult_neg");
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    do_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_neg");
    do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    do_op(MD_DIVU,  32'h0000_1234, 32'h0000_0000, 1'b0, "divu_zero");
    do_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 1'b0, "div_zero_neg");
    do_op(MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 1'b0, "div_posneg");
  endtask

  task automatic test_move();
    logic [31:0] v;
    @(negedge clk); Start = 1'b1; MDOp = MD_MTHI; SrcA = 32'hA5A5_A5A5;
    @(posedge clk); #1; Start = 1'b0;
    total++;
    if (HI !== 32'hA5A5_A5A5 || LO !== cur_lo || Busy !== 1'b0) begin
      bad++; $display("FAIL mthi got hi=%h lo=%h busy=%b want hi=a5a5a5a5 lo=%h busy=0", HI, LO, Busy, cur_lo);
    end
    cur_hi = 32'hA5A5_A5A5;
    v = $urandom;
    @(negedge clk); Start = 1'b1; MDOp = MD_MTLO; SrcA = v;
    @(posedge clk); #1; Start = 1'b0;
    total++;
    if (LO !== v || HI !== cur_hi || Busy !== 1'b0) begin
      bad++; $display("FAIL mtlo got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", HI, LO, Busy, cur_hi, v);
    end
    cur_lo = v;
    for (int k = 6; k < 8; k++) begin
      @(negedge clk); Start = 1'b1; MDOp = 3'(k); SrcA = $urandom; SrcB = $urandom;
      @(posedge clk); #1; Start = 1'b0;
      total++;
      if (HI !== cur_hi || LO !== cur_lo || Busy !== 1'b0) begin
        bad++; $display("FAIL noop%0d got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", k, HI, LO, Busy, cur_hi, cur_lo);
      end
    end
  endtask

  task automatic test_busy_ignore();
    do_op(MD_MULT, 32'h0001_2345, 32'hFFFF_0F00, 1'b1, "inject_mult");
    do_op(MD_DIVU, 32'hDEAD_BEEF, 32'h0000_0013, 1'b1, "inject_divu");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk); Start = 1'b1; MDOp = MD_MULT; SrcA = 32'd3; SrcB = 32'd5;
    @(posedge clk); #1; Start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (Busy !== 1'b1) begin
      bad++; $display("FAIL midrun_busy got=%b want=1", Busy);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      bad++; $display("FAIL reset_midop got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO);
    end
    @(negedge clk); rst = 1'b0;
    cur_hi = 32'h0; cur_lo = 32'h0;
    do_op(MD_MULT, 32'd3, 32'd5, 1'b0, "mult_after_reset");
  endtask

  task automatic test_random_ops();
    logic [31:0] a, b;
    logic [2:0]  op;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 300));
        default: ;
      endcase
      do_op(op, a, b, 1'b0, "random");
    end
  endtask

  // Back-to-back issue: each op starts in the first idle cycle after the last.
  task automatic test_back_to_back();
    do_op(MD_DIV,   32'h7FFF_FFFF, 32'h0000_0003, 1'b0, "b2b_div");
    do_op(MD_MULTU, 32'h8000_0001, 32'h0000_0002, 1'b0, "b2b_multu");
    do_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, "b2b_mult");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_move();
    test_busy_ignore();
    test_reset_mid_op();
    test_random_ops();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, alongside the ALU, fed from the same register-file operands.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO into architectural HI/LO registers.
- HI/LO outputs go to the writeback mux, beside the ALU Result, for MFHI/MFLO.
- Busy is the stall request to the control unit while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width. Only 32 is required to work.
- ITER, 32, iterations per multiply/divide. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only when Busy=0
- MDOp  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
- SrcA  input  32  rs operand (multiplicand/dividend; MTHI/MTLO data)
- SrcB  input  32  rt operand (multiplier/divisor)
- Busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset: one clk edge with rst=1 sets HI=0, LO=0, Busy=0 and the FSM to IDLE. This applies mid-operation too; the in-flight result is discarded.
- FSM states:
  - IDLE:
    - Start=1 with MTHI/MTLO: HI (resp. LO) <= SrcA at that edge. No Busy. Stay IDLE.
    - Start=1 with MULT..DIVU: latch operands, op and sign flags; counter <= 0; Busy <= 1; go to RUN.
    - Start=1 with a no-op encoding: ignored.
  - RUN: one shift-add (multiply) or restore-subtract (divide) step per cycle, ITER steps total.
    - On the edge completing step ITER: apply sign correction, write HI/LO, Busy <= 0, go to IDLE.
- Latency:
  - Busy is high for exactly 32 cycles, starting the cycle after the accepting edge.
  - HI/LO hold old values throughout RUN and change only on the same edge Busy falls.
  - A Start may be accepted in the first cycle Busy=0 after completion.
- Start while Busy=1 is ignored entirely, including MTHI/MTLO. Control must stall.
- Operands and MDOp are sampled only at the accepting edge. Later changes to them have no effect.
- Multiply:
  - Operate on magnitudes; negate the 64-bit product if signed and the operand signs differ.
  - {HI,LO} = 64-bit product. MULTU treats both operands as unsigned.
- Divide (signed): magnitude division.
  - Quotient truncates toward zero; negate it if signs differ.
  - Remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Overflow: 0x80000000 / -1 gives LO=0x80000000, HI=0. No exception.
- Divide by zero (DIV/DIVU): still takes 32 cycles. LO=0xFFFFFFFF, HI=SrcA as latched (unsigned raw bits).
- HI/LO are written only at completion, by MTHI/MTLO, or by reset.

Decomposition:
- Shared package (md_pkg): MDOp encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO; FSM state encodings IDLE/RUN; WIDTH constant.
- Sub-module md_sign_fix: combinational abs on entry and conditional negate of the 64-bit result/quotient/remainder on exit, shared by multiply and divide.
- Iteration datapath and FSM stay in mul_div_unit.

Test Plan:
- MULT SrcA=7, SrcB=0xFFFFFFFD -> Busy high for exactly 32 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB. HI/LO unchanged while Busy.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV SrcA=0xFFFFFFF9 (-7), SrcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU SrcA=0x1234, SrcB=0 -> after 32 cycles LO=0xFFFFFFFF, HI=0x00001234.
- MTHI SrcA=0xA5A5A5A5 with Busy=0 -> HI=0xA5A5A5A5 next edge, Busy stays 0. Start with MTLO and with MULT during RUN -> ignored; LO and final result unaffected.
- Start MULT 3x5, assert rst at cycle 10 of RUN -> next edge Busy=0, HI=LO=0. A fresh MULT 3x5 then gives LO=15, HI=0.
